// File: rtl/noc_nhr_pkg.sv
// Shared types and sizing helpers for the next-hop register bank.
package noc_nhr_pkg;

  // Per-channel route-lock state.
  typedef enum logic [1:0] {
    NHR_IDLE   = 2'd0,
    NHR_ROUTED = 2'd1,
    NHR_DRAIN  = 2'd2
  } nhr_state_t;

  // Drain counter width: enough to hold DRAIN_CYCLES-1, never narrower than one bit.
  function automatic int unsigned nhr_cnt_w(input int unsigned drain_cycles);
    int unsigned w;
    w = $clog2(drain_cycles + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int unsigned NHR_DRAIN_CYCLES_DEF = 2;
  localparam int unsigned NHR_CNT_W            = nhr_cnt_w(NHR_DRAIN_CYCLES_DEF);

endpackage

// File: rtl/nexthop_channel.sv
// One channel of the next-hop bank: route-lock FSM, address register,
// drain counter and sticky error flag. All outputs come straight from flops.
module nexthop_channel
  import noc_nhr_pkg::*;
#(
  parameter int unsigned        ADDR_W       = 3,
  parameter logic [ADDR_W-1:0]  DEFAULT_ADDR = ADDR_W'(1),
  parameter int unsigned        DRAIN_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ib_empty_i,
  input  logic              pt_almost_done_i,
  input  logic              nhr_write_i,
  input  logic [ADDR_W-1:0] nhr_address_i,
  output logic [ADDR_W-1:0] nhr_address_o,
  output logic              nhr_valid_o,
  output logic              nhr_busy_o,
  output logic              nhr_err_o
);

  localparam int unsigned      CNT_W     = nhr_cnt_w(DRAIN_CYCLES);
  localparam bit               HAS_DRAIN = (DRAIN_CYCLES > 0);
  // Loaded on packet completion; DRAIN then lasts exactly DRAIN_CYCLES cycles.
  localparam logic [CNT_W-1:0] CNT_LOAD  = HAS_DRAIN ? CNT_W'(DRAIN_CYCLES - 1) : '0;

  nhr_state_t        state_q, state_d;
  logic [ADDR_W-1:0] addr_q,  addr_d;
  logic [CNT_W-1:0]  cnt_q,   cnt_d;
  logic              err_q,   err_d;
  logic              valid_q, valid_d;
  logic              busy_q,  busy_d;

  // State, address, counter and flag registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= NHR_IDLE;
      addr_q  <= DEFAULT_ADDR;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  // Next-state logic; conditions inside each state are prioritised top-down.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    err_d   = err_q;

    unique case (state_q)
      NHR_IDLE: begin
        // A write against an empty buffer has no packet behind it; drop it silently.
        if (nhr_write_i && !ib_empty_i) begin
          state_d = NHR_ROUTED;
          addr_d  = nhr_address_i;
        end else begin
          addr_d  = DEFAULT_ADDR;
        end
      end

      NHR_ROUTED: begin
        // The route is locked for the whole packet; any rewrite is a writer bug.
        if (nhr_write_i) begin
          err_d = 1'b1;
        end
        if (ib_empty_i) begin
          // Buffer ran dry: abandon the packet without draining.
          state_d = NHR_IDLE;
          addr_d  = DEFAULT_ADDR;
        end else if (pt_almost_done_i) begin
          // Drop the route now so the next header cannot inherit a stale one.
          state_d = HAS_DRAIN ? NHR_DRAIN : NHR_IDLE;
          addr_d  = DEFAULT_ADDR;
          cnt_d   = CNT_LOAD;
        end
      end

      NHR_DRAIN: begin
        if (nhr_write_i) begin
          err_d = 1'b1;
        end
        addr_d = DEFAULT_ADDR;
        if (cnt_q == '0) begin
          state_d = NHR_IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      default: begin
        state_d = NHR_IDLE;
        addr_d  = DEFAULT_ADDR;
        cnt_d   = '0;
      end
    endcase
  end

  // Status flags are decoded from the next state so they register alongside it.
  always_comb begin
    valid_d = (state_d == NHR_ROUTED);
    busy_d  = (state_d != NHR_IDLE);
  end

  assign nhr_address_o = addr_q;
  assign nhr_valid_o   = valid_q;
  assign nhr_busy_o    = busy_q;
  assign nhr_err_o     = err_q;

endmodule

// File: rtl/nexthop_register_bank.sv
// Per-input-channel next-hop registers between route compute and the
// output-port arbiter. Channels are independent; this level only packs and
// unpacks the per-channel address buses.
module nexthop_register_bank
  import noc_nhr_pkg::*;
#(
  parameter int unsigned        N_CH         = 5,
  parameter int unsigned        ADDR_W       = 3,
  parameter logic [ADDR_W-1:0]  DEFAULT_ADDR = ADDR_W'(1),
  parameter int unsigned        DRAIN_CYCLES = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [N_CH-1:0]          ib_empty_i,
  input  logic [N_CH-1:0]          pt_almost_done_i,
  input  logic [N_CH-1:0]          nhr_write_i,
  input  logic [N_CH*ADDR_W-1:0]   nhr_address_i,
  output logic [N_CH*ADDR_W-1:0]   nhr_address_o,
  output logic [N_CH-1:0]          nhr_valid_o,
  output logic [N_CH-1:0]          nhr_busy_o,
  output logic [N_CH-1:0]          nhr_err_o
);

  // One independent route-lock channel per input port.
  for (genvar c = 0; c < int'(N_CH); c++) begin : g_ch
    nexthop_channel #(
      .ADDR_W       (ADDR_W),
      .DEFAULT_ADDR (DEFAULT_ADDR),
      .DRAIN_CYCLES (DRAIN_CYCLES)
    ) u_ch (
      .clk              (clk),
      .reset            (reset),
      .ib_empty_i       (ib_empty_i[c]),
      .pt_almost_done_i (pt_almost_done_i[c]),
      .nhr_write_i      (nhr_write_i[c]),
      .nhr_address_i    (nhr_address_i[c*ADDR_W +: ADDR_W]),
      .nhr_address_o    (nhr_address_o[c*ADDR_W +: ADDR_W]),
      .nhr_valid_o      (nhr_valid_o[c]),
      .nhr_busy_o       (nhr_busy_o[c]),
      .nhr_err_o        (nhr_err_o[c])
    );
  end

endmodule

// File: tb/tb_nexthop_register_bank.sv
// Scoreboard bench: two bank builds (5ch/3b/drain2 and 8ch/4b/drain0) share
// clock and reset; each stimulus step queues hand-derived expected outputs.
module tb_nexthop_register_bank;

  localparam int unsigned A_N = 5;
  localparam int unsigned A_W = 3;
  localparam int unsigned B_N = 8;
  localparam int unsigned B_W = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic [A_N-1:0]     a_empty, a_done, a_wr, a_valid, a_busy, a_err;
  logic [A_N*A_W-1:0] a_addr_in, a_addr_out;
  logic [B_N-1:0]     b_empty, b_done, b_wr, b_valid, b_busy, b_err;
  logic [B_N*B_W-1:0] b_addr_in, b_addr_out;

  nexthop_register_bank dut_a (
    .clk              (clk),
    .reset            (reset),
    .ib_empty_i       (a_empty),
    .pt_almost_done_i (a_done),
    .nhr_write_i      (a_wr),
    .nhr_address_i    (a_addr_in),
    .nhr_address_o    (a_addr_out),
    .nhr_valid_o      (a_valid),
    .nhr_busy_o       (a_busy),
    .nhr_err_o        (a_err)
  );

  nexthop_register_bank #(
    .N_CH         (8),
    .ADDR_W       (4),
    .DEFAULT_ADDR (4'b0001),
    .DRAIN_CYCLES (0)
  ) dut_b (
    .clk              (clk),
    .reset            (reset),
    .ib_empty_i       (b_empty),
    .pt_almost_done_i (b_done),
    .nhr_write_i      (b_wr),
    .nhr_address_i    (b_addr_in),
    .nhr_address_o    (b_addr_out),
    .nhr_valid_o      (b_valid),
    .nhr_busy_o       (b_busy),
    .nhr_err_o        (b_err)
  );

  // Staged stimulus, copied onto the DUT pins at the next falling edge.
  logic               s_rst;
  logic [A_N-1:0]     s_a_empty, s_a_done, s_a_wr;
  logic [A_N*A_W-1:0] s_a_addr;
  logic [B_N-1:0]     s_b_empty, s_b_done, s_b_wr;
  logic [B_N*B_W-1:0] s_b_addr;

  // Hand-maintained expectations for the outputs after the coming edge.
  logic [A_W-1:0] ea_addr [A_N];
  logic [A_N-1:0] ea_v, ea_b, ea_e;
  logic [B_W-1:0] eb_addr [B_N];
  logic [B_N-1:0] eb_v, eb_b, eb_e;

  logic [B_W-1:0] b_vals [B_N] = '{4'h3, 4'h9, 4'hE, 4'h5, 4'hC, 4'h0, 4'h7, 4'hA};

  typedef struct {
    string              name;
    logic [A_N*A_W-1:0] a_addr;
    logic [A_N-1:0]     a_v, a_b, a_e;
    logic [B_N*B_W-1:0] b_addr;
    logic [B_N-1:0]     b_v, b_b, b_e;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic clear_strobes();
    s_a_wr = '0; s_a_done = '0; s_a_empty = '0;
    s_b_wr = '0; s_b_done = '0; s_b_empty = '0;
  endtask

  task automatic step(input string name);
    exp_t e;
    @(negedge clk);
    reset     = s_rst;
    a_empty   = s_a_empty; a_done = s_a_done; a_wr = s_a_wr; a_addr_in = s_a_addr;
    b_empty   = s_b_empty; b_done = s_b_done; b_wr = s_b_wr; b_addr_in = s_b_addr;
    e.name = name;
    for (int c = 0; c < int'(A_N); c++) e.a_addr[c*A_W +: A_W] = ea_addr[c];
    for (int c = 0; c < int'(B_N); c++) e.b_addr[c*B_W +: B_W] = eb_addr[c];
    e.a_v = ea_v; e.a_b = ea_b; e.a_e = ea_e;
    e.b_v = eb_v; e.b_b = eb_b; e.b_e = eb_e;
    sb.push_back(e);
  endtask

  // Monitor: every edge with a pending expectation is checked 1 time unit later.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      e = sb.pop_front();
      checks++;
      if (a_addr_out !== e.a_addr || a_valid !== e.a_v || a_busy !== e.a_b || a_err !== e.a_e) begin
        errors++;
        $display("FAIL %s bankA: got addr=%h valid=%b busy=%b err=%b, want addr=%h valid=%b busy=%b err=%b",
                 e.name, a_addr_out, a_valid, a_busy, a_err, e.a_addr, e.a_v, e.a_b, e.a_e);
      end
      checks++;
      if (b_addr_out !== e.b_addr || b_valid !== e.b_v || b_busy !== e.b_b || b_err !== e.b_e) begin
        errors++;
        $display("FAIL %s bankB: got addr=%h valid=%b busy=%b err=%b, want addr=%h valid=%b busy=%b err=%b",
                 e.name, b_addr_out, b_valid, b_busy, b_err, e.b_addr, e.b_v, e.b_b, e.b_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset = 1'b1;
    a_empty = '0; a_done = '0; a_wr = '0; a_addr_in = '0;
    b_empty = '0; b_done = '0; b_wr = '0; b_addr_in = '0;
    s_rst = 1'b1; s_a_addr = '0; s_b_addr = '0;
    clear_strobes();
    for (int c = 0; c < int'(A_N); c++) ea_addr[c] = 3'b001;
    for (int c = 0; c < int'(B_N); c++) eb_addr[c] = 4'b0001;
    ea_v = '0; ea_b = '0; ea_e = '0;
    eb_v = '0; eb_b = '0; eb_e = '0;

    step("reset");
    s_rst = 1'b0;
    for (int i = 0; i < 5; i++) step("idle");

    // Channel 0: lock, then a rewrite while locked flags a sticky error.
    s_a_wr[0] = 1'b1; s_a_addr[2:0] = 3'b100;
    ea_addr[0] = 3'b100; ea_v[0] = 1'b1; ea_b[0] = 1'b1;
    step("ch0_lock");
    clear_strobes();
    step("ch0_hold");
    s_a_wr[0] = 1'b1; s_a_addr[2:0] = 3'b010;
    ea_e[0] = 1'b1;
    step("ch0_write_routed");
    clear_strobes();
    step("ch0_err_sticky");

    // Channel 2: completion drains for two cycles, then a fresh write locks again.
    s_a_wr[2] = 1'b1; s_a_addr[8:6] = 3'b110;
    ea_addr[2] = 3'b110; ea_v[2] = 1'b1; ea_b[2] = 1'b1;
    step("ch2_lock");
    clear_strobes();
    s_a_done[2] = 1'b1;
    ea_addr[2] = 3'b001; ea_v[2] = 1'b0;
    step("ch2_drain_1");
    clear_strobes();
    step("ch2_drain_2");
    ea_b[2] = 1'b0;
    step("ch2_idle");
    s_a_wr[2] = 1'b1; s_a_addr[8:6] = 3'b011;
    ea_addr[2] = 3'b011; ea_v[2] = 1'b1; ea_b[2] = 1'b1;
    step("ch2_relock");
    clear_strobes();
    s_a_done[2] = 1'b1;
    ea_addr[2] = 3'b001; ea_v[2] = 1'b0;
    step("ch2_drain_again");
    clear_strobes();
    s_a_wr[2] = 1'b1; s_a_empty[2] = 1'b1; s_a_addr[8:6] = 3'b111;
    ea_e[2] = 1'b1;
    step("ch2_write_empty_in_drain");
    clear_strobes();
    ea_b[2] = 1'b0;
    step("ch2_drain_done");

    // Channel 1: empty beats completion, no drain.
    s_a_wr[1] = 1'b1; s_a_addr[5:3] = 3'b101;
    ea_addr[1] = 3'b101; ea_v[1] = 1'b1; ea_b[1] = 1'b1;
    step("ch1_lock");
    clear_strobes();
    s_a_done[1] = 1'b1; s_a_empty[1] = 1'b1;
    ea_addr[1] = 3'b001; ea_v[1] = 1'b0; ea_b[1] = 1'b0;
    step("ch1_done_and_empty");
    clear_strobes();
    step("ch1_stays_idle");

    // Channel 0 still locked: buffer running dry drops it, error stays.
    s_a_empty[0] = 1'b1;
    ea_addr[0] = 3'b001; ea_v[0] = 1'b0; ea_b[0] = 1'b0;
    step("ch0_buffer_dry");
    clear_strobes();

    // Channel 3: write against empty buffer and stray completion are ignored.
    s_a_wr[3] = 1'b1; s_a_empty[3] = 1'b1; s_a_addr[11:9] = 3'b110;
    step("ch3_write_empty");
    clear_strobes();
    s_a_done[3] = 1'b1;
    step("ch3_done_idle");
    clear_strobes();

    // Channel 4: reset mid-packet aborts the lock and clears all errors.
    s_a_wr[4] = 1'b1; s_a_addr[14:12] = 3'b010;
    ea_addr[4] = 3'b010; ea_v[4] = 1'b1; ea_b[4] = 1'b1;
    step("ch4_lock");
    clear_strobes();
    step("ch4_hold");
    s_rst = 1'b1; s_a_wr[4] = 1'b1;
    for (int c = 0; c < int'(A_N); c++) ea_addr[c] = 3'b001;
    ea_v = '0; ea_b = '0; ea_e = '0;
    step("reset_mid_packet");
    s_rst = 1'b0;
    clear_strobes();
    step("after_reset");

    // Bank B: all channels written at once, then zero-cycle drain.
    for (int c = 0; c < int'(B_N); c++) begin
      s_b_wr[c] = 1'b1;
      s_b_addr[c*B_W +: B_W] = b_vals[c];
      eb_addr[c] = b_vals[c];
    end
    eb_v = '1; eb_b = '1;
    step("b_lock_all");
    clear_strobes();
    step("b_hold_all");
    s_b_done = '1;
    for (int c = 0; c < int'(B_N); c++) eb_addr[c] = 4'b0001;
    eb_v = '0; eb_b = '0;
    step("b_done_direct_idle");
    clear_strobes();
    s_b_wr[5] = 1'b1; s_b_addr[23:20] = 4'hB;
    eb_addr[5] = 4'hB; eb_v[5] = 1'b1; eb_b[5] = 1'b1;
    step("b_ch5_lock");
    clear_strobes();
    s_b_done[5] = 1'b1; s_b_wr[5] = 1'b1; s_b_addr[23:20] = 4'h6;
    eb_addr[5] = 4'b0001; eb_v[5] = 1'b0; eb_b[5] = 1'b0; eb_e[5] = 1'b1;
    step("b_done_plus_write");
    clear_strobes();
    step("b_final");

    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_scoreboard: %0d expectations left, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nexthop_register_bank.md
Name: nexthop_register_bank

Overview:
- Parametrised successor to the single-port next-hop register.
- Holds one next-hop address per input channel of a NoC router arbiter, with a per-channel route-lock FSM.
- A route is latched once per packet. It is held stable until the packet transfer completes, then drains for a programmable number of cycles before returning to the default port.
- Sits between the route-compute/header-decode logic (writer) and the output-port arbiter (reader).

Parameters:
- N_CH, 5, number of input channels (one next-hop register plus FSM each)
- ADDR_W, 3, width of a next-hop port address
- DEFAULT_ADDR, 3'b001, address driven while a channel is idle (local port)
- DRAIN_CYCLES, 2, cycles held in DRAIN after packet completion (legal range 0..15)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- ib_empty_i  in  N_CH  input buffer empty, per channel
- pt_almost_done_i  in  N_CH  packet transfer finishing this cycle, per channel
- nhr_write_i  in  N_CH  write strobe, per channel
- nhr_address_i  in  N_CH*ADDR_W  next-hop address, packed; channel c uses bits [c*ADDR_W +: ADDR_W]
- nhr_address_o  out  N_CH*ADDR_W  registered next-hop address, packed the same way
- nhr_valid_o  out  N_CH  channel holds a locked route (state ROUTED)
- nhr_busy_o  out  N_CH  channel not IDLE (ROUTED or DRAIN)
- nhr_err_o  out  N_CH  sticky: a write was attempted while ROUTED/DRAIN; cleared only by reset

Behaviour:
- All outputs are registered and have 1-cycle latency from the inputs.
- Channels are fully independent and share no state.
- Reset (sync, high) sets every channel to:
  - state IDLE
  - nhr_address_o = DEFAULT_ADDR
  - nhr_valid_o = 0, nhr_busy_o = 0, nhr_err_o = 0
  - drain counter = 0
- Reset mid-packet aborts the lock immediately on the next edge.
- Per-channel FSM, with priority evaluated top-down in each state:
  - IDLE:
    - nhr_write_i & !ib_empty_i -> ROUTED; address <= nhr_address_i.
    - nhr_write_i & ib_empty_i -> write ignored; stay IDLE; no error.
    - Otherwise hold DEFAULT_ADDR.
  - ROUTED:
    - ib_empty_i -> IDLE; address <= DEFAULT_ADDR. Buffer ran dry, so the packet is abandoned.
    - Else pt_almost_done_i -> DRAIN if DRAIN_CYCLES > 0, else straight to IDLE. Address <= DEFAULT_ADDR in both cases, so a new header cannot reuse a stale route. Counter <= DRAIN_CYCLES-1.
    - Else hold the address.
    - Any nhr_write_i in ROUTED is ignored and sets nhr_err_o, including a write in the same cycle as pt_almost_done_i.
  - DRAIN:
    - Counter decrements each cycle; at 0 -> IDLE.
    - nhr_write_i sets nhr_err_o and is discarded.
    - ib_empty_i has no effect in DRAIN.
- Output derivation: nhr_valid_o = (state==ROUTED); nhr_busy_o = (state!=IDLE).
- Simultaneous pt_almost_done_i and ib_empty_i in ROUTED: ib_empty_i wins -> IDLE with no drain.
- pt_almost_done_i in IDLE or DRAIN is ignored.
- The drain counter is $clog2(DRAIN_CYCLES+1) bits wide, minimum 1. No wrap: it saturates at 0.
- Addresses are passed through unchecked. Values >= router port count are the writer's responsibility.

Decomposition:
- Package noc_nhr_pkg holds:
  - nhr_state_t enum {NHR_IDLE, NHR_ROUTED, NHR_DRAIN}, 2 bits
  - localparam NHR_CNT_W function of DRAIN_CYCLES
- Sub-module nexthop_channel holds the FSM, the address register, the counter and the error flag for one channel.
- The top level generates N_CH instances and handles packing/unpacking.

Test Plan:
- Reset, then idle 5 cycles -> all nhr_address_o = 3'b001; valid, busy and err all 0.
- Ch0 write 3'b100 with ib_empty=0 -> next cycle addr0 = 3'b100, valid0 = 1. A write of 3'b010 two cycles later -> addr0 stays 3'b100, err0 = 1 sticky.
- Ch2 ROUTED, pt_almost_done pulse, DRAIN_CYCLES=2:
  - next cycle addr2 = 3'b001, valid2 = 0, busy2 = 1 for exactly 2 cycles, then IDLE.
  - A write at cycle 3 of this sequence is accepted.
- Ch1 ROUTED, pt_almost_done=1 and ib_empty=1 in the same cycle -> next cycle IDLE, busy1 = 0 (no drain).
- Ch3 write with ib_empty=1 -> remains IDLE, addr = 3'b001, err3 = 0. Reset asserted while ch4 ROUTED -> next cycle ch4 IDLE, err cleared.
- Rebuild with N_CH=8, ADDR_W=4, DRAIN_CYCLES=0 and write distinct addresses on all channels at once -> each output slice matches its own input. pt_almost_done returns directly to IDLE in 1 cycle.
